// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA 640x480 timing types, constants and checker state
package vga_timing_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int VGA_LOCK_FRAMES = 2;

    typedef struct packed {
        logic valid;
        logic hsync_n;
        logic vsync_n;
        logic blank_n;
        logic end_of_line;
        logic end_of_frame;
    } VGA_Timing;

    typedef enum logic [1:0] {
        CHK_SEARCH = 2'd0,
        CHK_TRACK  = 2'd1,
        CHK_LOCKED = 2'd2
    } chk_state_e;

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/vga_edge_detect.sv
// rtl/vga_edge_detect.sv - strobe-qualified edge detection on hsync_n, vsync_n and blank_n
module vga_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic valid_i,
    input  logic hsync_n_i,
    input  logic vsync_n_i,
    input  logic blank_n_i,
    output logic hs_fall_o,
    output logic vs_fall_o,
    output logic bl_rise_o,
    output logic bl_fall_o
);

    logic hs_q, vs_q, bl_q;
    logic hs_d, vs_d, bl_d;

    always_comb begin
        hs_d = hs_q;
        vs_d = vs_q;
        bl_d = bl_q;
        if (valid_i) begin
            hs_d = hsync_n_i;
            vs_d = vsync_n_i;
            bl_d = blank_n_i;
        end
    end

    // Idle sync levels are high, so a stream starting low reads as a fall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            bl_q <= 1'b1;
        end else begin
            hs_q <= hs_d;
            vs_q <= vs_d;
            bl_q <= bl_d;
        end
    end

    assign hs_fall_o = valid_i &  hs_q & ~hsync_n_i;
    assign vs_fall_o = valid_i &  vs_q & ~vsync_n_i;
    assign bl_rise_o = valid_i & ~bl_q &  blank_n_i;
    assign bl_fall_o = valid_i &  bl_q & ~blank_n_i;

endmodule

// File: rtl/vga_timing_checker.sv
// rtl/vga_timing_checker.sv - recovers pixel coordinates from a VGA timing stream and verifies geometry
module vga_timing_checker
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE   = VGA_H_VISIBLE,
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int V_VISIBLE   = VGA_V_VISIBLE,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  VGA_Timing  timing_i,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       pix_valid_o,
    output logic       frame_start_o,
    output logic       locked_o,
    output logic [7:0] err_count_o
);

    logic strobe;
    logic hs_fall, vs_fall, bl_rise, bl_fall;
    logic unused_eol_eof;

    assign strobe         = timing_i.valid;
    assign unused_eol_eof = timing_i.end_of_line | timing_i.end_of_frame;

    vga_edge_detect u_edge (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .valid_i   (timing_i.valid),
        .hsync_n_i (timing_i.hsync_n),
        .vsync_n_i (timing_i.vsync_n),
        .blank_n_i (timing_i.blank_n),
        .hs_fall_o (hs_fall),
        .vs_fall_o (vs_fall),
        .bl_rise_o (bl_rise),
        .bl_fall_o (bl_fall)
    );

    chk_state_e state_q, state_d;
    logic [3:0] good_q, good_d;
    logic [9:0] hcnt_q, hcnt_d;
    logic       h_ref_q, h_ref_d;
    logic [9:0] run_q, run_d;
    logic [9:0] lcnt_q, lcnt_d;
    logic [9:0] acnt_q, acnt_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [7:0] err_q, err_d;
    logic       pix_valid_q, pix_valid_d;
    logic       frame_start_q, frame_start_d;

    logic       tracking;
    logic       h_err, w_err, f_err, any_err;
    logic [9:0] x_cur;

    always_comb begin
        tracking = (state_q != CHK_SEARCH);
        h_err    = hs_fall & h_ref_q & (({1'b0, hcnt_q} + 11'd1) != 11'(H_TOTAL));
        w_err    = bl_fall & (run_q != 10'(H_VISIBLE));
        f_err    = vs_fall & ((lcnt_q != 10'(V_TOTAL)) | (acnt_q != 10'(V_VISIBLE)));
        any_err  = tracking & (h_err | w_err | f_err);

        hcnt_d  = hcnt_q;
        h_ref_d = h_ref_q;
        if (hs_fall) begin
            hcnt_d  = '0;
            h_ref_d = 1'b1;
        end else if (strobe) begin
            hcnt_d = sat_inc10(hcnt_q);
        end

        x_cur = bl_rise ? 10'd0 : run_q;
        run_d = run_q;
        x_d   = x_q;
        y_d   = y_q;
        if (strobe & timing_i.blank_n) begin
            run_d = sat_inc10(x_cur);
            x_d   = x_cur;
            y_d   = acnt_q;
        end

        // The frame check above sees the pre-edge counts; a coincident hsync opens the new frame.
        lcnt_d = lcnt_q;
        acnt_d = acnt_q;
        if (vs_fall) begin
            lcnt_d = hs_fall ? 10'd1 : 10'd0;
            acnt_d = bl_fall ? 10'd1 : 10'd0;
        end else if (tracking) begin
            if (hs_fall) lcnt_d = sat_inc10(lcnt_q);
            if (bl_fall) acnt_d = sat_inc10(acnt_q);
        end

        err_d = err_q;
        if (any_err && (err_q != 8'hFF)) err_d = err_q + 8'd1;

        pix_valid_d   = strobe & timing_i.blank_n & (state_q == CHK_LOCKED);
        frame_start_d = vs_fall;

        // An error found on a vsync fall drops to search and consumes that fall as the
        // search exit, so a steadily wrong frame length is counted on every frame.
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            CHK_SEARCH: begin
                if (vs_fall) begin
                    state_d = CHK_TRACK;
                    good_d  = '0;
                end
            end
            CHK_TRACK, CHK_LOCKED: begin
                if (any_err) begin
                    state_d = vs_fall ? CHK_TRACK : CHK_SEARCH;
                    good_d  = '0;
                end else if (vs_fall && (state_q == CHK_TRACK)) begin
                    good_d = good_q + 4'd1;
                    if (good_d == 4'(LOCK_FRAMES)) state_d = CHK_LOCKED;
                end
            end
            default: begin
                state_d = CHK_SEARCH;
                good_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= CHK_SEARCH;
            good_q        <= '0;
            hcnt_q        <= '0;
            h_ref_q       <= 1'b0;
            run_q         <= '0;
            lcnt_q        <= '0;
            acnt_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            err_q         <= '0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            good_q        <= good_d;
            hcnt_q        <= hcnt_d;
            h_ref_q       <= h_ref_d;
            run_q         <= run_d;
            lcnt_q        <= lcnt_d;
            acnt_q        <= acnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            err_q         <= err_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign x_o           = x_q;
    assign y_o           = y_q;
    assign pix_valid_o   = pix_valid_q;
    assign frame_start_o = frame_start_q;
    assign locked_o      = (state_q == CHK_LOCKED);
    assign err_count_o   = err_q;

endmodule

// File: tb/tb_vga_timing_checker.sv
// tb/tb_vga_timing_checker.sv - scoreboard bench for vga_timing_checker on a reduced geometry
module tb_vga_timing_checker;
    import vga_timing_pkg::*;

    localparam int HV = 8, HF = 2, HS = 2, HB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VV = 4, VF = 1, VS = 1, VB = 1;
    localparam int VT = VV + VF + VS + VB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    VGA_Timing  tmg;
    logic [9:0] x_o, y_o;
    logic       pix_valid_o, frame_start_o, locked_o;
    logic [7:0] err_count_o;

    always #5 clk = ~clk;

    vga_timing_checker #(
        .H_VISIBLE   (HV),
        .H_TOTAL     (HT),
        .V_VISIBLE   (VV),
        .V_TOTAL     (VT),
        .LOCK_FRAMES (2)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .timing_i      (tmg),
        .x_o           (x_o),
        .y_o           (y_o),
        .pix_valid_o   (pix_valid_o),
        .frame_start_o (frame_start_o),
        .locked_o      (locked_o),
        .err_count_o   (err_count_o)
    );

    int total = 0;
    int bad   = 0;
    int div   = 4;
    int pushed = 0;
    int seen   = 0;
    int good_falls = 0;
    int vs_seen    = 0;
    int exp_err    = 0;
    bit exp_lock   = 1'b0;
    bit bad_mode   = 1'b0;
    bit coinc      = 1'b0;
    bit prev_vs    = 1'b1;
    logic [19:0] exp_q[$];
    logic [19:0] mon_e;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && pix_valid_o) begin
            if (exp_q.size() == 0) begin
                chk_eq("pix_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                seen++;
                chk_eq("pix_x", 32'(x_o), 32'(mon_e[19:10]));
                chk_eq("pix_y", 32'(y_o), 32'(mon_e[9:0]));
            end
        end
    end

    task automatic strobe(input logic hs, input logic vs, input logic bl,
                          input int px, input int py, input bit glitch);
        bit vfall;
        vfall = prev_vs && !vs;
        tmg.valid   = 1'b1;
        tmg.hsync_n = hs;
        tmg.vsync_n = vs;
        tmg.blank_n = bl;
        if (bl && exp_lock) begin
            exp_q.push_back({10'(px), 10'(py)});
            pushed++;
        end
        prev_vs = vs;
        @(posedge clk);
        #1;
        tmg.valid = 1'b0;
        chk_eq("frame_start", 32'(frame_start_o), 32'(vfall));
        if (vfall) begin
            if (bad_mode) begin
                if (vs_seen > 0 && exp_err < 255) exp_err++;
                vs_seen++;
            end else if (good_falls < 3) begin
                good_falls++;
            end
            exp_lock = !bad_mode && (good_falls >= 3);
            chk_eq("locked_at_vs", 32'(locked_o), 32'(exp_lock));
            chk_eq("err_at_vs", 32'(err_count_o), 32'(exp_err));
        end
        if (glitch) begin
            exp_err++;
            exp_lock   = 1'b0;
            good_falls = 0;
            chk_eq("glitch_err", 32'(err_count_o), 32'(exp_err));
            chk_eq("glitch_unlock", 32'(locked_o), 32'd0);
        end
        repeat (div - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk_eq("rst_x", 32'(x_o), 32'd0);
        chk_eq("rst_y", 32'(y_o), 32'd0);
        chk_eq("rst_pix_valid", 32'(pix_valid_o), 32'd0);
        chk_eq("rst_frame_start", 32'(frame_start_o), 32'd0);
        chk_eq("rst_locked", 32'(locked_o), 32'd0);
        chk_eq("rst_err", 32'(err_count_o), 32'd0);
        tmg = '0;
        repeat (3) @(posedge clk);
        pushed -= exp_q.size();
        exp_q.delete();
        good_falls = 0;
        vs_seen    = 0;
        exp_err    = 0;
        exp_lock   = 1'b0;
        prev_vs    = 1'b1;
        #1 rst_n = 1'b1;
    endtask

    task automatic run_frame(input int extra, input int glitch_line, input int gap_line,
                             input int rst_line);
        int   vt;
        int   vs_start;
        int   s;
        logic hs, vs, bl;
        vt       = VT + extra;
        vs_start = (VV + VF) * HT + (coinc ? (HV + HF) : 0);
        for (int l = 0; l < vt; l++) begin
            for (int p = 0; p < HT; p++) begin
                s  = l * HT + p;
                hs = !((p >= HV + HF) && (p < HV + HF + HS));
                vs = !((s >= vs_start) && (s < vs_start + VS * HT));
                bl = (p < HV) && (l < VV);
                if (l == glitch_line && p == 3) hs = 1'b0;
                strobe(hs, vs, bl, p, l, (l == glitch_line && p == 3));
                if (l == gap_line && p == 4) begin
                    repeat (10000) @(posedge clk);
                    #1;
                    chk_eq("gap_x_hold", 32'(x_o), 32'd4);
                    chk_eq("gap_y_hold", 32'(y_o), 32'(gap_line));
                    chk_eq("gap_locked", 32'(locked_o), 32'd1);
                    chk_eq("gap_err", 32'(err_count_o), 32'(exp_err));
                end
                if (l == rst_line && p == 2) do_reset();
            end
        end
    endtask

    initial begin
        tmg = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("init_x", 32'(x_o), 32'd0);
        chk_eq("init_y", 32'(y_o), 32'd0);
        chk_eq("init_pix_valid", 32'(pix_valid_o), 32'd0);
        chk_eq("init_frame_start", 32'(frame_start_o), 32'd0);
        chk_eq("init_locked", 32'(locked_o), 32'd0);
        chk_eq("init_err", 32'(err_count_o), 32'd0);
        rst_n = 1'b1;

        for (int f = 0; f < 5; f++) run_frame(0, -1, -1, -1);
        chk_eq("clean_err", 32'(err_count_o), 32'd0);
        chk_eq("clean_locked", 32'(locked_o), 32'd1);

        run_frame(0, 1, -1, -1);
        for (int f = 0; f < 4; f++) run_frame(0, -1, -1, -1);
        chk_eq("relock", 32'(locked_o), 32'd1);
        chk_eq("relock_err", 32'(err_count_o), 32'd1);

        run_frame(0, -1, 2, -1);
        chk_eq("gap_after_err", 32'(err_count_o), 32'd1);

        run_frame(0, -1, -1, 1);
        for (int f = 0; f < 3; f++) run_frame(0, -1, -1, -1);
        chk_eq("post_rst_locked", 32'(locked_o), 32'd1);
        chk_eq("post_rst_err", 32'(err_count_o), 32'd0);

        do_reset();
        coinc = 1'b1;
        for (int f = 0; f < 5; f++) run_frame(0, -1, -1, -1);
        chk_eq("coinc_err", 32'(err_count_o), 32'd0);
        chk_eq("coinc_locked", 32'(locked_o), 32'd1);

        do_reset();
        coinc    = 1'b0;
        div      = 1;
        bad_mode = 1'b1;
        for (int f = 0; f < 260; f++) run_frame(1, -1, -1, -1);
        chk_eq("sat_err", 32'(err_count_o), 32'd255);
        chk_eq("sat_locked", 32'(locked_o), 32'd0);

        repeat (4) @(posedge clk);
        #1;
        chk_eq("pix_left", 32'(exp_q.size()), 32'd0);
        chk_eq("pix_seen", 32'(seen), 32'(pushed));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
